// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// ---------------------------------------------------------------------------
// PS/2 device-to-host receiver. Synchronises and glitch-filters the raw
// PS2_CLK / PS2_DATA pins, deserialises 11-bit frames (start, 8 data LSB
// first, odd parity, stop), folds the E0 (extended) and F0 (break) prefixes
// into flags on the following code and queues completed key events in a
// small FIFO for the keyboard matrix logic.
//
// Ports
//   clk         system clock
//   nRESET      synchronous, active-low reset
//   clk_en      sampling/advance enable for filter, FSM and timeout
//   PS2_CLK     raw PS/2 clock pin (asynchronous)
//   PS2_DATA    raw PS/2 data pin (asynchronous)
//   code        scan code of the FIFO head event
//   extended    head event was preceded by E0
//   released    head event was preceded by F0
//   valid       FIFO non-empty; code/extended/released are meaningful
//   ack         consumer pop request
//   parity_err  one-clk_en-tick pulse on a parity failure
//   frame_err   one-clk_en-tick pulse on bad start/stop bit or timeout
//   overflow    sticky: an event was dropped because the FIFO was full
//   dbg_state   current receive FSM state (state_t encoding)
//
// Handshake: the head event is held stable while valid=1. It is consumed on
// every clk edge where valid & ack are both high (independent of clk_en);
// ack while valid=0 has no effect. No pop is implied by valid alone.
// ---------------------------------------------------------------------------
module ps2_scancode_rx #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 1000,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] code,
    output logic       extended,
    output logic       released,
    output logic       valid,
    input  logic       ack,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic [1:0] dbg_state
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [15:0] TMO   = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ---------------- registers ----------------
    logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
    logic                  filt_q, filt_d;
    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [15:0]           tmo_q, tmo_d;
    logic                  ext_q, ext_d;
    logic                  rel_q, rel_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [9:0]            mem_q [DEPTH];
    logic [9:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH_LOG2:0]   fcnt_q, fcnt_d;
    logic                  ovf_q, ovf_d;

    // ---------------- combinational helpers ----------------
    logic       fall;
    logic       bit_in;
    logic       byte_ok;
    logic       push_req;
    logic [9:0] push_ev;
    logic       pop;
    logic       full;
    logic       do_push;

    // ---------------- clock filter ----------------
    // The filter shifts in the synchronised clock on every clk_en tick and
    // only changes level once the whole window agrees, so pulses shorter
    // than FILTER_LEN ticks never reach the FSM.
    always_comb begin
        filt_sh_d = filt_sh_q;
        filt_d    = filt_q;
        if (clk_en) begin
            filt_sh_d = {filt_sh_q[FILTER_LEN-2:0], clk_s2_q};
            if (filt_sh_d == '0) begin
                filt_d = 1'b0;
            end else if (filt_sh_d == '1) begin
                filt_d = 1'b1;
            end
        end
    end

    assign fall   = clk_en & filt_q & ~filt_d;
    assign bit_in = dat_s2_q;

    // ---------------- receive FSM ----------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        ext_d     = ext_q;
        rel_d     = rel_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        byte_ok   = 1'b0;
        push_req  = 1'b0;
        push_ev   = {rel_q, ext_q, shift_q};

        if (clk_en) begin
            // Error outputs are pulses lasting exactly one clk_en tick.
            perr_d = 1'b0;
            ferr_d = 1'b0;

            if (state_q == S_IDLE) begin
                tmo_d = 16'd0;
            end else if (fall) begin
                tmo_d = 16'd0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        if (!bit_in) begin
                            state_d   = S_DATA;
                            bit_cnt_d = 3'd0;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (fall) begin
                        shift_d   = {bit_in, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (fall) begin
                        par_d   = bit_in;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall) begin
                        state_d = S_IDLE;
                        // Parity failure takes precedence over a bad stop bit.
                        if ((^{shift_q, par_q}) == 1'b0) begin
                            perr_d = 1'b1;
                            ext_d  = 1'b0;
                            rel_d  = 1'b0;
                        end else if (!bit_in) begin
                            ferr_d = 1'b1;
                            ext_d  = 1'b0;
                            rel_d  = 1'b0;
                        end else begin
                            byte_ok = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A stalled partial frame is abandoned along with any prefix.
            if (state_q != S_IDLE && !fall && tmo_d == TMO) begin
                state_d = S_IDLE;
                ferr_d  = 1'b1;
                ext_d   = 1'b0;
                rel_d   = 1'b0;
            end
        end

        if (byte_ok) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                push_req = 1'b1;
                ext_d    = 1'b0;
                rel_d    = 1'b0;
            end
        end
    end

    // ---------------- event FIFO ----------------
    assign valid = (fcnt_q != '0);
    assign full  = (fcnt_q == (DEPTH_LOG2+1)'(DEPTH));
    assign pop   = valid & ack;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_req & (~full | pop);

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fcnt_d = fcnt_q;
        ovf_d  = ovf_q;
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (do_push) begin
            mem_d[wr_q] = push_ev;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !pop) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (!do_push && pop) begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_sh_q <= '1;
            filt_q    <= 1'b1;
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            tmo_q     <= 16'd0;
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wr_q      <= '0;
            rd_q      <= '0;
            fcnt_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            clk_s1_q  <= PS2_CLK;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= PS2_DATA;
            dat_s2_q  <= dat_s1_q;
            filt_sh_q <= filt_sh_d;
            filt_q    <= filt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            rel_q     <= rel_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            fcnt_q    <= fcnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // ---------------- outputs ----------------
    assign code       = mem_q[rd_q][7:0];
    assign extended   = mem_q[rd_q][8];
    assign released   = mem_q[rd_q][9];
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx
// Directed bench for ps2_scancode_rx: a table of byte sequences with the
// single key event each must produce, followed by hand-written sequences for
// errors, timeout, FIFO fill/overflow, glitch rejection and mid-frame reset.
module tb_ps2_scancode_rx;

    localparam int H = 30;   // PS/2 half bit period in clk cycles

    logic       clk;
    logic       nRESET;
    logic       clk_en;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       valid;
    logic       ack;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int pe_cnt = 0;
    int fe_cnt = 0;
    logic pe_prev = 1'b0;
    logic fe_prev = 1'b0;

    ps2_scancode_rx #(
        .FILTER_LEN(4),
        .TIMEOUT   (1000),
        .DEPTH_LOG2(2)
    ) dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .clk_en    (clk_en),
        .PS2_CLK   (ps2_clk),
        .PS2_DATA  (ps2_data),
        .code      (code),
        .extended  (extended),
        .released  (released),
        .valid     (valid),
        .ack       (ack),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clk_en ticks every second clk.
    initial begin
        clk_en = 1'b0;
        forever begin
            @(negedge clk);
            clk_en = ~clk_en;
        end
    end

    // Error pulse counters (rising edges).
    always @(negedge clk) begin
        if (parity_err && !pe_prev) pe_cnt++;
        if (frame_err && !fe_prev) fe_cnt++;
        pe_prev = parity_err;
        fe_prev = frame_err;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRESET = 1'b0;
        repeat (4) @(negedge clk);
        nRESET = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_bad,
                                             input logic stop_v);
        logic p;
        p = (~(^b)) ^ par_bad;
        return {stop_v, p, b, 1'b0};
    endfunction

    // Device-side driver: data changes while clock high, then clock low.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic par_bad, input logic stop_v);
        send_bits(mk_frame(b, par_bad, stop_v), 11);
        repeat (H) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b, 1'b0, 1'b1);
    endtask

    task automatic pop_one();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [7:0] c,
                              input logic e, input logic r);
        check({name, ".valid"},    32'(valid),    32'd1);
        check({name, ".code"},     32'(code),     32'(c));
        check({name, ".extended"}, 32'(extended), 32'(e));
        check({name, ".released"}, 32'(released), 32'(r));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [7:0] bsel;
        logic [7:0] exp_q[$];
        int pe0, fe0;
        int budget;
        logic seen;

        nRESET   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ack      = 1'b0;

        vecs[0] = '{8'h1C, 8'h00, 8'h00, 1, 8'h1C, 1'b0, 1'b0};
        vecs[1] = '{8'hF0, 8'h1C, 8'h00, 2, 8'h1C, 1'b0, 1'b1};
        vecs[2] = '{8'hE0, 8'h75, 8'h00, 2, 8'h75, 1'b1, 1'b0};
        vecs[3] = '{8'hE0, 8'hF0, 8'h75, 3, 8'h75, 1'b1, 1'b1};
        vecs[4] = '{8'hE0, 8'hE0, 8'h6B, 3, 8'h6B, 1'b1, 1'b0};
        vecs[5] = '{8'hE1, 8'h00, 8'h00, 1, 8'hE1, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h00, 8'h00, 1, 8'hAA, 1'b0, 1'b0};
        vecs[7] = '{8'hFA, 8'h00, 8'h00, 1, 8'hFA, 1'b0, 1'b0};
        vecs[8] = '{8'hF0, 8'hE0, 8'h74, 3, 8'h74, 1'b1, 1'b1};
        vecs[9] = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 1'b0, 1'b0};

        // ---- reset state ----
        repeat (5) @(negedge clk);
        check("rst.valid",      32'(valid),      32'd0);
        check("rst.code",       32'(code),       32'd0);
        check("rst.extended",   32'(extended),   32'd0);
        check("rst.released",   32'(released),   32'd0);
        check("rst.parity_err", 32'(parity_err), 32'd0);
        check("rst.frame_err",  32'(frame_err),  32'd0);
        check("rst.overflow",   32'(overflow),   32'd0);
        check("rst.state",      32'(dbg_state),  32'd0);
        nRESET = 1'b1;
        repeat (4) @(negedge clk);

        // ---- ack on empty FIFO is ignored ----
        pop_one();
        check("ack_empty.valid", 32'(valid), 32'd0);

        // ---- first frame: no event before stop bit, event after ----
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 10);
        check("pre_stop.valid", 32'(valid), 32'd0);
        send_bits(11'b111_1111_1111, 1);
        repeat (H) @(negedge clk);
        check_head("first", 8'h1C, 1'b0, 1'b0);
        pop_one();
        check("first.popped", 32'(valid), 32'd0);

        // ---- table ----
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                bsel = (j == 0) ? vecs[i].b0 : ((j == 1) ? vecs[i].b1 : vecs[i].b2);
                send_byte(bsel);
            end
            check_head($sformatf("vec%0d", i), vecs[i].code, vecs[i].ext, vecs[i].rel);
            pop_one();
            check($sformatf("vec%0d.popped", i), 32'(valid), 32'd0);
        end
        check("table.pe_cnt", 32'(pe_cnt), 32'd0);
        check("table.fe_cnt", 32'(fe_cnt), 32'd0);

        // ---- two queued events, in order ----
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check_head("q0", 8'h1C, 1'b0, 1'b1);
        pop_one();
        check_head("q1", 8'h75, 1'b1, 1'b1);
        pop_one();
        check("q.empty", 32'(valid), 32'd0);

        // ---- parity error clears prefix ----
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_byte(8'hE0);
        send_raw(8'h1C, 1'b1, 1'b1);
        check("par.pe_pulse", 32'(pe_cnt - pe0), 32'd1);
        check("par.fe_none",  32'(fe_cnt - fe0), 32'd0);
        check("par.no_event", 32'(valid), 32'd0);
        send_byte(8'h1C);
        check_head("par.after", 8'h1C, 1'b0, 1'b0);
        pop_one();

        // ---- bad stop bit clears prefix ----
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_byte(8'hF0);
        send_raw(8'h1C, 1'b0, 1'b0);
        check("stop.fe_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("stop.pe_none",  32'(pe_cnt - pe0), 32'd0);
        check("stop.no_event", 32'(valid), 32'd0);
        send_byte(8'h1C);
        check_head("stop.after", 8'h1C, 1'b0, 1'b0);
        pop_one();

        // ---- both faults: only parity_err ----
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_raw(8'h2E, 1'b1, 1'b0);
        check("both.pe_pulse", 32'(pe_cnt - pe0), 32'd1);
        check("both.fe_none",  32'(fe_cnt - fe0), 32'd0);
        check("both.no_event", 32'(valid), 32'd0);

        // ---- start bit high in IDLE ----
        fe0 = fe_cnt;
        send_bits(11'b111_1111_1111, 1);
        repeat (H) @(negedge clk);
        check("start1.fe_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("start1.state",    32'(dbg_state),    32'd0);

        // ---- glitch on PS2_CLK ----
        pe0 = pe_cnt; fe0 = fe_cnt;
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch.state", 32'(dbg_state),      32'd0);
        check("glitch.fe",    32'(fe_cnt - fe0),   32'd0);
        check("glitch.pe",    32'(pe_cnt - pe0),   32'd0);
        check("glitch.valid", 32'(valid),          32'd0);

        // ---- timeout mid-frame ----
        fe0 = fe_cnt;
        send_byte(8'hE0);
        send_bits(mk_frame(8'h75, 1'b0, 1'b1), 5);
        check("tmo.midframe", 32'(dbg_state), 32'd1);
        repeat (2200) @(negedge clk);
        check("tmo.fe_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("tmo.state",    32'(dbg_state),    32'd0);
        check("tmo.no_event", 32'(valid),        32'd0);
        send_byte(8'h75);
        check_head("tmo.after", 8'h75, 1'b0, 1'b0);
        pop_one();

        // ---- overflow ----
        exp_q = '{8'h16, 8'h1E, 8'h26, 8'h25};
        send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26); send_byte(8'h25);
        check("ovf.before", 32'(overflow), 32'd0);
        send_byte(8'h2E);
        check("ovf.set", 32'(overflow), 32'd1);
        while (exp_q.size() > 0) begin
            check_head("ovf.pop", exp_q.pop_front(), 1'b0, 1'b0);
            pop_one();
        end
        check("ovf.empty", 32'(valid),    32'd0);
        check("ovf.sticky", 32'(overflow), 32'd1);

        // ---- push coincident with pop when full ----
        do_reset();
        check("rst2.overflow", 32'(overflow), 32'd0);
        send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26); send_byte(8'h25);
        seen = 1'b0;
        fork
            send_byte(8'h2E);
            begin
                budget = 2000;
                while (!seen && budget > 0) begin
                    @(negedge clk);
                    #1;
                    if (dut.push_req) begin
                        seen = 1'b1;
                        ack  = 1'b1;
                        @(negedge clk);
                        ack = 1'b0;
                    end
                    budget--;
                end
            end
        join
        check("coinc.push_seen", 32'(seen),     32'd1);
        check("coinc.overflow",  32'(overflow), 32'd0);
        exp_q = '{8'h1E, 8'h26, 8'h25, 8'h2E};
        while (exp_q.size() > 0) begin
            check_head("coinc.pop", exp_q.pop_front(), 1'b0, 1'b0);
            pop_one();
        end
        check("coinc.empty", 32'(valid), 32'd0);

        // ---- reset mid-frame ----
        send_byte(8'hE0);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5);
        do_reset();
        check("midrst.state", 32'(dbg_state), 32'd0);
        check("midrst.valid", 32'(valid),     32'd0);
        send_byte(8'h1C);
        check_head("midrst.after", 8'h1C, 1'b0, 1'b0);
        pop_one();
        check("midrst.empty", 32'(valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
